systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Upstream operand feeder for the N×N output-stationary systolic MAC array. It accepts one A and one B matrix through a valid/ready handshake and clears the array's accumulators. It then drives the left edge with skewed rows of A and the top edge with skewed columns of B, zero-padded. It signals `done` once the last product has been accumulated in the bottom-right PE.

## Interface
- `N`, 2: array dimension (rows = columns); legal range 1..8
- `W`, 8: operand width, matching the PE operand ports
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-low
- `in_valid`  in  1  A/B matrices presented
- `in_ready`  out  1  feeder can accept matrices
- `a_flat`  in  N*N*W  A row-major; A[i][k] at bits (i*N+k)*W +: W
- `b_flat`  in  N*N*W  B row-major; B[k][j] at bits (k*N+j)*W +: W
- `a_row`  out  N*W  lane i (bits i*W +: W) drives `a_in` of PE(i,0)
- `b_col`  out  N*W  lane j drives `b_in` of PE(0,j)
- `pe_rst`  out  1  active-high clear to every PE's `rst`
- `busy`  out  1  job in progress (not IDLE)
- `done`  out  1  one-cycle pulse; array results are final

## Operation
- FSM states: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- IDLE: `in_ready`=1. A handshake is `in_valid && in_ready` at a rising edge. On a handshake, latch `a_flat`/`b_flat` into internal registers and go to CLEAR.
- CLEAR: one cycle, `pe_rst`=1, lanes 0. Go to FEED with step t=0.
- FEED: 2N-1 cycles, t=0..2N-2.
  - `a_row` lane i = A[i][t-i] if 0 ≤ t-i < N, else 0.
  - `b_col` lane j = B[t-j][j] if 0 ≤ t-j < N, else 0.
  - After t=2N-2: go to DRAIN, or to DONE if N=1.
- DRAIN: N-1 cycles, lanes 0, waiting for skewed data to reach PE(N-1,N-1).
- DONE: one cycle, `done`=1, lanes 0, then IDLE.
- `in_ready`=0 in all states except IDLE. `in_valid` outside IDLE is ignored, and input buses are don't-care after the latch.
- Step/drain counter is $clog2(2N) bits wide and resets to 0 on each state entry.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, counters 0, latched matrices 0.
  - Outputs while `rst`=0: `in_ready`=0, `busy`=0, `done`=0, lanes 0, `pe_rst`=1 (holds the array clear).
  - First cycle after release: `in_ready`=1, `pe_rst`=0.
- Handshake at the end of cycle 0:
  - cycle 1: CLEAR
  - cycles 2..2N: FEED
  - cycles 2N+1..3N-1: DRAIN
  - cycle 3N: DONE
  - cycle 3N+1: IDLE, `in_ready`=1
- N=2: `done` is in cycle 6, and the next handshake is possible at the end of cycle 7.
- `busy`=1 from cycle 1 through cycle 3N inclusive.
- Reset mid-job aborts immediately: no `done`, job discarded, array cleared via `pe_rst`.
- `in_valid` held high across a job: a second handshake occurs only in the first IDLE cycle after DONE.

## Configuration
- `SYSTOLIC_FEEDER_CNT_EN` defined:
  - Adds output `job_cnt`, out, 16 bits.
  - Reset value 0; increments in the DONE cycle and is visible the following cycle.
  - Wraps 0xFFFF → 0x0000.
- Not defined: port and counter absent; all other behaviour is identical.

## Structure
- Shared package `systolic_pkg`:
  - default `N` and `W` constants
  - state enum `feeder_state_t` (IDLE, CLEAR, FEED, DRAIN, DONE)
  - helper function for the counter width
- One natural sub-module, `skew_lane`: given latched row/column data, lane index and step t, produces the lane's operand or 0. It is instantiated N times for A and N times for B.
- The FSM and counters stay in `systolic_feeder`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, `pe_rst`=1, lanes 0, no handshake. After release, `in_ready`=1.
- N=2 schedule: A=[[1,2],[3,4]], B=[[5,6],[7,8]].
  - `a_row` (lane1,lane0) over FEED steps: (0,1), (3,2), (4,0).
  - `b_col` (lane1,lane0): (0,5), (6,7), (8,0).
  - `done` in cycle 6.
- Integration with a 2×2 PE array, same A/B → after `done`, c00=19, c01=22, c10=43, c11=50. A second job A=I, B=[[9,8],[7,6]] gives 9,8,7,6, confirming the clear.
- Back-to-back `in_valid` held high → exactly one handshake per job, spaced 7 cycles apart (N=2). `busy` is low only in the handshake cycle.
- Abort: drive `rst`=0 during FEED step 1 → no `done`, `pe_rst`=1. A fresh job then completes with correct results.
- With `SYSTOLIC_FEEDER_CNT_EN`: 3 jobs → `job_cnt`=3. Preload near wrap with 0xFFFF + 1 job → 0x0000.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array operand feeder.
// Contents:
//   DEFAULT_N / DEFAULT_W : default array dimension and operand width
//   feeder_state_t        : feeder FSM state encoding
//   cnt_width()           : width of the step/drain counter for a given N
package systolic_pkg;

  localparam int unsigned DEFAULT_N = 2;
  localparam int unsigned DEFAULT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } feeder_state_t;

  // Step counter must hold 0..2N-2 (FEED) and 0..N-2 (DRAIN).
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_lane.sv
// skew_lane: one edge lane of the systolic feeder.
// Given the N operands destined for this lane (a row of A or a column of B,
// element k at bits k*W +: W), the lane index IDX and the FEED step t_i,
// outputs element (t_i - IDX) when that index lies in 0..N-1 and en_i is
// set, otherwise 0.
// Ports:
//   vec_i : N*W  operands for this lane
//   en_i  : 1    feeder is in FEED
//   t_i   : CW   current FEED step
//   op_o  : W    operand driven onto the array edge
module skew_lane
  import systolic_pkg::*;
#(
  parameter int unsigned N   = DEFAULT_N,
  parameter int unsigned W   = DEFAULT_W,
  parameter int unsigned IDX = 0,
  parameter int unsigned CW  = cnt_width(DEFAULT_N)
) (
  input  logic [N*W-1:0] vec_i,
  input  logic           en_i,
  input  logic [CW-1:0]  t_i,
  output logic [W-1:0]   op_o
);

  always_comb begin
    op_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (en_i && (t_i == CW'(IDX + k))) begin
        op_o = vec_i[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: operand feeder for an N x N output-stationary MAC array.
// Accepts one A/B matrix pair via valid/ready, clears the array, streams
// skewed rows of A (left edge) and columns of B (top edge), waits for the
// skew to drain, then pulses done.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   in_valid/in_ready : matrix handshake (ready only in IDLE)
//   a_flat, b_flat    : A and B, row-major, element (r,c) at (r*N+c)*W +: W
//   a_row, b_col      : skewed edge lanes, lane i at i*W +: W
//   pe_rst            : active-high clear for every PE
//   busy, done        : job in progress / one-cycle completion pulse
//   job_cnt           : 16-bit completed-job counter, present only when
//                       SYSTOLIC_FEEDER_CNT_EN is defined
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N,
  parameter int unsigned W = DEFAULT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] a_flat,
  input  logic [N*N*W-1:0] b_flat,
  output logic [N*W-1:0]   a_row,
  output logic [N*W-1:0]   b_col,
  output logic             pe_rst,
  output logic             busy,
  output logic             done
`ifdef SYSTOLIC_FEEDER_CNT_EN
  ,
  output logic [15:0]      job_cnt
`endif
);

  localparam int unsigned   CW         = cnt_width(N);
  localparam logic [CW-1:0] FEED_LAST  = CW'(2 * N - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'((N > 1) ? N - 2 : 0);

  feeder_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N*N*W-1:0] a_q, a_d, b_q, b_d;
  logic             in_ready_q, in_ready_d;
  logic             pe_rst_q, pe_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SYSTOLIC_FEEDER_CNT_EN
  logic [15:0]      job_cnt_q, job_cnt_d;
`endif

  // Status outputs are registered from the state being entered, so each
  // *_d below describes the cycle after the current edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    in_ready_d = 1'b0;
    pe_rst_d   = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
`ifdef SYSTOLIC_FEEDER_CNT_EN
    job_cnt_d  = job_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d  = CLEAR;
          cnt_d    = '0;
          a_d      = a_flat;
          b_d      = b_flat;
          pe_rst_d = 1'b1;
        end else begin
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      CLEAR: begin
        state_d = FEED;
        cnt_d   = '0;
      end
      FEED: begin
        if (cnt_q == FEED_LAST) begin
          cnt_d = '0;
          if (N == 1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d    = IDLE;
        cnt_d      = '0;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
`ifdef SYSTOLIC_FEEDER_CNT_EN
        job_cnt_d  = job_cnt_q + 16'd1;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      in_ready_q <= 1'b0;
      pe_rst_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SYSTOLIC_FEEDER_CNT_EN
      job_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      in_ready_q <= in_ready_d;
      pe_rst_q   <= pe_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SYSTOLIC_FEEDER_CNT_EN
      job_cnt_q  <= job_cnt_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign pe_rst   = pe_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef SYSTOLIC_FEEDER_CNT_EN
  assign job_cnt  = job_cnt_q;
`endif

  // Lanes are decoded from registered state and latched data only.
  logic feeding;
  assign feeding = (state_q == FEED);

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [N*W-1:0] col;
    for (genvar k = 0; k < N; k++) begin : g_col
      assign col[k*W +: W] = b_q[(k*N+g)*W +: W];
    end

    skew_lane #(.N(N), .W(W), .IDX(g), .CW(CW)) u_a_lane (
      .vec_i (a_q[g*N*W +: N*W]),
      .en_i  (feeding),
      .t_i   (cnt_q),
      .op_o  (a_row[g*W +: W])
    );

    skew_lane #(.N(N), .W(W), .IDX(g), .CW(CW)) u_b_lane (
      .vec_i (col),
      .en_i  (feeding),
      .t_i   (cnt_q),
      .op_o  (b_col[g*W +: W])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder: drives jobs, checks the cycle schedule and
// lane contents against the skew rule, and feeds a behavioural 2x2
// output-stationary PE array whose results are compared with A*B.
module tb_systolic_feeder;

  localparam int unsigned N = 2;
  localparam int unsigned W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N*N*W-1:0] a_flat, b_flat;
  logic [N*W-1:0]   a_row, b_col;
  logic             pe_rst, busy, done;
`ifdef SYSTOLIC_FEEDER_CNT_EN
  logic [15:0]      job_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] ma [N][N];
  logic [W-1:0] mb [N][N];

  always #5 clk = ~clk;

  systolic_feeder #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_flat   (a_flat),
    .b_flat   (b_flat),
    .a_row    (a_row),
    .b_col    (b_col),
    .pe_rst   (pe_rst),
    .busy     (busy),
    .done     (done)
`ifdef SYSTOLIC_FEEDER_CNT_EN
    ,
    .job_cnt  (job_cnt)
`endif
  );

  // Behavioural output-stationary PE array attached to the feeder lanes.
  logic [W-1:0] pa [N][N];
  logic [W-1:0] pb [N][N];
  logic [31:0]  acc [N][N];
  logic [W-1:0] pe_a, pe_b;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pe_a = (j == 0) ? a_row[i*W +: W] : pa[i][(j == 0) ? 0 : j-1];
        pe_b = (i == 0) ? b_col[j*W +: W] : pb[(i == 0) ? 0 : i-1][j];
        if (pe_rst) begin
          acc[i][j] <= '0;
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + 32'(pe_a) * 32'(pe_b);
          pa[i][j]  <= pe_a;
          pb[i][j]  <= pe_b;
        end
      end
    end
  end

  function automatic logic [W-1:0] exp_a(input int i, input int t);
    if (t - i >= 0 && t - i < int'(N)) return ma[i][t-i];
    return '0;
  endfunction

  function automatic logic [W-1:0] exp_b(input int j, input int t);
    if (t - j >= 0 && t - j < int'(N)) return mb[t-j][j];
    return '0;
  endfunction

  task automatic pack_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_flat[(i*N+k)*W +: W] = ma[i][k];
        b_flat[(i*N+k)*W +: W] = mb[i][k];
      end
  endtask

  task automatic rand_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = W'($urandom_range(0, 255));
        mb[i][k] = W'($urandom_range(0, 255));
      end
  endtask

  task automatic wait_ready(input string tag);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: in_ready=%b required 1", tag, in_ready);
    end
  endtask

  // One full job starting from IDLE; the handshake cycle is cycle 0.
  task automatic test_job(input string tag);
    logic [N*W-1:0] ea, eb;
    logic [31:0]    cref;
    int             t;
    bit             feed;
    wait_ready(tag);
    pack_mats();
    in_valid = 1'b1;
    for (int c = 1; c <= 3*int'(N)+1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_valid = 1'b0;
        a_flat   = ~a_flat;
        b_flat   = ~b_flat;
      end
      feed = (c >= 2 && c <= 2*int'(N));
      t    = c - 2;
      for (int i = 0; i < N; i++) begin
        ea[i*W +: W] = feed ? exp_a(i, t) : '0;
        eb[i*W +: W] = feed ? exp_b(i, t) : '0;
      end
      checks++;
      if (in_ready !== (c == 3*int'(N)+1)) begin
        errors++;
        $display("FAIL %s c%0d in_ready: got %b want %b", tag, c, in_ready, (c == 3*int'(N)+1));
      end
      checks++;
      if (busy !== (c <= 3*int'(N))) begin
        errors++;
        $display("FAIL %s c%0d busy: got %b want %b", tag, c, busy, (c <= 3*int'(N)));
      end
      checks++;
      if (done !== (c == 3*int'(N))) begin
        errors++;
        $display("FAIL %s c%0d done: got %b want %b", tag, c, done, (c == 3*int'(N)));
      end
      checks++;
      if (pe_rst !== (c == 1)) begin
        errors++;
        $display("FAIL %s c%0d pe_rst: got %b want %b", tag, c, pe_rst, (c == 1));
      end
      checks++;
      if (a_row !== ea) begin
        errors++;
        $display("FAIL %s c%0d a_row: got %h want %h", tag, c, a_row, ea);
      end
      checks++;
      if (b_col !== eb) begin
        errors++;
        $display("FAIL %s c%0d b_col: got %h want %h", tag, c, b_col, eb);
      end
      if (c == 3*int'(N)) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            cref = '0;
            for (int k = 0; k < N; k++) cref += 32'(ma[i][k]) * 32'(mb[k][j]);
            checks++;
            if (acc[i][j] !== cref) begin
              errors++;
              $display("FAIL %s c%0d_%0d result: got %0d want %0d", tag, i, j, acc[i][j], cref);
            end
          end
      end
    end
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    in_valid = 1'b1;
    a_flat   = '1;
    b_flat   = '1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pe_rst !== 1'b1) begin
        errors++;
        $display("FAIL reset_ctrl: ready=%b busy=%b done=%b pe_rst=%b want 0 0 0 1",
                 in_ready, busy, done, pe_rst);
      end
      checks++;
      if (a_row !== '0 || b_col !== '0) begin
        errors++;
        $display("FAIL reset_lanes: a_row=%h b_col=%h want 0", a_row, b_col);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || pe_rst !== 1'b0) begin
      errors++;
      $display("FAIL release: ready=%b busy=%b pe_rst=%b want 1 0 0", in_ready, busy, pe_rst);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_integration();
    ma[0][0] = 8'd1; ma[0][1] = 8'd2; ma[1][0] = 8'd3; ma[1][1] = 8'd4;
    mb[0][0] = 8'd5; mb[0][1] = 8'd6; mb[1][0] = 8'd7; mb[1][1] = 8'd8;
    test_job("sched");
    checks++;
    if (acc[0][0] !== 32'd19 || acc[0][1] !== 32'd22 || acc[1][0] !== 32'd43 || acc[1][1] !== 32'd50) begin
      errors++;
      $display("FAIL integ_ab: got %0d %0d %0d %0d want 19 22 43 50",
               acc[0][0], acc[0][1], acc[1][0], acc[1][1]);
    end
    ma[0][0] = 8'd1; ma[0][1] = 8'd0; ma[1][0] = 8'd0; ma[1][1] = 8'd1;
    mb[0][0] = 8'd9; mb[0][1] = 8'd8; mb[1][0] = 8'd7; mb[1][1] = 8'd6;
    test_job("ident");
    checks++;
    if (acc[0][0] !== 32'd9 || acc[0][1] !== 32'd8 || acc[1][0] !== 32'd7 || acc[1][1] !== 32'd6) begin
      errors++;
      $display("FAIL integ_ident: got %0d %0d %0d %0d want 9 8 7 6",
               acc[0][0], acc[0][1], acc[1][0], acc[1][1]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      rand_mats();
      test_job($sformatf("rand%0d", r));
    end
  endtask

  task automatic test_back_to_back();
    int hs = 0;
    int dn = 0;
    int last = -1;
    wait_ready("b2b");
    rand_mats();
    pack_mats();
    in_valid = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (in_ready === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 7) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want 7", c - last);
          end
        end
        hs++;
        last = c;
      end
      checks++;
      if (busy !== (c % 7 != 0)) begin
        errors++;
        $display("FAIL b2b_busy c%0d: got %b want %b", c, busy, (c % 7 != 0));
      end
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (hs != 3 || dn != 3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count: handshakes=%0d dones=%0d ready=%b want 3 3 1", hs, dn, in_ready);
    end
  endtask

  task automatic test_abort();
    int dn = 0;
    wait_ready("abort");
    rand_mats();
    pack_mats();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pe_rst !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: pe_rst=%b done=%b busy=%b ready=%b want 1 0 0 0",
               pe_rst, done, busy, in_ready);
    end
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    checks++;
    if (dn != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_nodone: dones=%0d ready=%b want 0 1", dn, in_ready);
    end
    rand_mats();
    test_job("abort_fresh");
  endtask

`ifdef SYSTOLIC_FEEDER_CNT_EN
  task automatic test_job_cnt();
    logic [15:0] base;
    base = job_cnt;
    for (int r = 0; r < 3; r++) begin
      rand_mats();
      test_job("cnt");
    end
    checks++;
    if (job_cnt !== base + 16'd3) begin
      errors++;
      $display("FAIL job_cnt: got %h want %h", job_cnt, base + 16'd3);
    end
    dut.job_cnt_q = 16'hFFFF;
    rand_mats();
    test_job("cnt_wrap");
    checks++;
    if (job_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL job_cnt_wrap: got %h want 0000", job_cnt);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_integration();
    test_random();
    test_back_to_back();
    test_abort();
`ifdef SYSTOLIC_FEEDER_CNT_EN
    test_job_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
